// File: rtl/mem_stage.sv
// MIPS memory stage: EXE/MEM boundary register, wait-stated data memory,
// MEM/WB register and the architectural HI register.
module mem_stage #(
    parameter int WORD_LEN    = 32,
    parameter int DEPTH       = 64,
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN_in,
    input  logic                MEM_W_EN_in,
    input  logic                WB_EN_in,
    input  logic                HI_W_EN_in,
    input  logic [4:0]          dest_in,
    input  logic [WORD_LEN-1:0] ALUResult_in,
    input  logic [WORD_LEN-1:0] ST_value_in,
    input  logic [WORD_LEN-1:0] high_in,
    output logic                freeze,
    output logic [WORD_LEN-1:0] ALU_res_MEM,
    output logic                WB_EN_MEM,
    output logic                MEM_R_EN_MEM,
    output logic [4:0]          dest_MEM,
    output logic                WB_EN_WB,
    output logic                MEM_R_EN_WB,
    output logic [4:0]          dest_WB,
    output logic [WORD_LEN-1:0] ALU_res_WB,
    output logic [WORD_LEN-1:0] MEM_data_WB,
    output logic [WORD_LEN-1:0] HI_reg,
    output logic                addr_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);
    localparam logic [WORD_LEN-1:0] BASE = WORD_LEN'(ADDR_BASE);
    localparam logic [WORD_LEN-1:0] SPAN = WORD_LEN'(4 * DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // EXE/MEM boundary register
    logic                wb_en_q;
    logic                mem_r_q;
    logic                mem_w_q;
    logic                hi_w_q;
    logic [4:0]          dest_q;
    logic [WORD_LEN-1:0] alu_q;
    logic [WORD_LEN-1:0] st_q;
    logic [WORD_LEN-1:0] high_q;

    // MEM/WB register
    logic                wb_en_wb_q;
    logic                mem_r_wb_q;
    logic [4:0]          dest_wb_q;
    logic [WORD_LEN-1:0] alu_wb_q;
    logic [WORD_LEN-1:0] data_wb_q;
    logic [WORD_LEN-1:0] hi_q;
    logic                addr_err_q;

    logic [WORD_LEN-1:0] mem_q [DEPTH];

    logic                mem_op;
    logic                is_load;
    logic                valid;
    logic                do_store;
    logic [WORD_LEN-1:0] offset;
    logic [IW-1:0]       idx;
    logic [WORD_LEN-1:0] load_data;

    always_comb begin
        mem_op    = mem_r_q | mem_w_q;
        is_load   = mem_r_q & ~mem_w_q;
        freeze    = mem_op & (cnt_q != CNT_MAX);
        // Wrap-around subtraction makes addresses below the base huge.
        offset    = alu_q - BASE;
        valid     = (offset[1:0] == 2'b00) && (offset < SPAN);
        idx       = offset[IW+1:2];
        do_store  = ~freeze & mem_w_q & valid;
        load_data = (is_load & valid) ? mem_q[idx] : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (freeze) begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q <= 1'b0;
            mem_r_q <= 1'b0;
            mem_w_q <= 1'b0;
            hi_w_q  <= 1'b0;
            dest_q  <= '0;
            alu_q   <= '0;
            st_q    <= '0;
            high_q  <= '0;
        end else if (!freeze) begin
            wb_en_q <= WB_EN_in;
            mem_r_q <= MEM_R_EN_in;
            mem_w_q <= MEM_W_EN_in;
            hi_w_q  <= HI_W_EN_in;
            dest_q  <= dest_in;
            alu_q   <= ALUResult_in;
            st_q    <= ST_value_in;
            high_q  <= high_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_wb_q <= 1'b0;
            mem_r_wb_q <= 1'b0;
            dest_wb_q  <= '0;
            alu_wb_q   <= '0;
            data_wb_q  <= '0;
            hi_q       <= '0;
            addr_err_q <= 1'b0;
        end else if (freeze) begin
            wb_en_wb_q <= 1'b0;
            mem_r_wb_q <= 1'b0;
            dest_wb_q  <= '0;
            alu_wb_q   <= '0;
            data_wb_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            wb_en_wb_q <= wb_en_q;
            mem_r_wb_q <= is_load;
            dest_wb_q  <= dest_q;
            alu_wb_q   <= alu_q;
            data_wb_q  <= load_data;
            addr_err_q <= mem_op & ~valid;
            if (hi_w_q) begin
                hi_q <= high_q;
            end
        end
    end

    // Contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem_q[idx] <= st_q;
        end
    end

    assign ALU_res_MEM  = alu_q;
    assign WB_EN_MEM    = wb_en_q;
    assign MEM_R_EN_MEM = mem_r_q;
    assign dest_MEM     = dest_q;
    assign WB_EN_WB     = wb_en_wb_q;
    assign MEM_R_EN_WB  = mem_r_wb_q;
    assign dest_WB      = dest_wb_q;
    assign ALU_res_WB   = alu_wb_q;
    assign MEM_data_WB  = data_wb_q;
    assign HI_reg       = hi_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model
// (word array, HI value, address-validity rule, fixed wait count).
module tb_mem_stage;

    localparam int W     = 32;
    localparam int DEP   = 64;
    localparam int BASE  = 1024;
    localparam int WAITC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          r_en, w_en, wb_en, hi_en;
    logic [4:0]    dest;
    logic [W-1:0]  alu, stv, hiv;
    logic          freeze;
    logic [W-1:0]  ALU_res_MEM;
    logic          WB_EN_MEM, MEM_R_EN_MEM;
    logic [4:0]    dest_MEM;
    logic          WB_EN_WB, MEM_R_EN_WB;
    logic [4:0]    dest_WB;
    logic [W-1:0]  ALU_res_WB, MEM_data_WB, HI_reg;
    logic          addr_err;

    mem_stage #(
        .WORD_LEN(W), .DEPTH(DEP), .ADDR_BASE(BASE), .WAIT_CYCLES(WAITC)
    ) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN_in(r_en), .MEM_W_EN_in(w_en),
        .WB_EN_in(wb_en), .HI_W_EN_in(hi_en),
        .dest_in(dest), .ALUResult_in(alu),
        .ST_value_in(stv), .high_in(hiv),
        .freeze(freeze), .ALU_res_MEM(ALU_res_MEM),
        .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM),
        .dest_MEM(dest_MEM),
        .WB_EN_WB(WB_EN_WB), .MEM_R_EN_WB(MEM_R_EN_WB),
        .dest_WB(dest_WB), .ALU_res_WB(ALU_res_WB),
        .MEM_data_WB(MEM_data_WB), .HI_reg(HI_reg),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem_m [DEP];
    logic [W-1:0] hi_m;
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        r_en = 0; w_en = 0; wb_en = 0; hi_en = 0;
        dest = 0; alu = 0; stv = 0; hiv = 0;
    endtask

    // Issue one op, follow it through its wait, check its commit.
    task automatic run_op(input logic r, input logic w, input logic wb,
                          input logic hw, input logic [4:0] d,
                          input logic [W-1:0] a, input logic [W-1:0] sv,
                          input logic [W-1:0] hv);
        int n;
        logic [W-1:0] off;
        logic ok, ld, memop;
        logic [W-1:0] exp_data;
        @(negedge clk);
        r_en = r; w_en = w; wb_en = wb; hi_en = hw;
        dest = d; alu = a; stv = sv; hiv = hv;
        @(posedge clk);
        #1 idle_inputs();
        memop = r | w;
        ld    = r & ~w;
        off   = a - W'(BASE);
        ok    = (off % 4 == 0) && (off < W'(4 * DEP));
        exp_data = (ld && ok) ? mem_m[off / 4] : '0;
        n = 0;
        @(negedge clk);
        while (freeze && n < 20) begin
            check("hold_alu_mem", ALU_res_MEM, a);
            check("hold_hi", HI_reg, hi_m);
            if (n > 0) begin
                check("bubble_ctl", {25'd0, WB_EN_WB, MEM_R_EN_WB, dest_WB}, '0);
                check("bubble_data", ALU_res_WB | MEM_data_WB, '0);
            end
            n++;
            @(negedge clk);
        end
        check("freeze_cycles", W'(n), memop ? W'(WAITC) : '0);
        @(posedge clk);
        #1;
        check("wb_en", {31'd0, WB_EN_WB}, {31'd0, wb});
        check("mem_r_wb", {31'd0, MEM_R_EN_WB}, {31'd0, ld});
        check("dest_wb", {27'd0, dest_WB}, {27'd0, d});
        check("alu_wb", ALU_res_WB, a);
        check("mem_data", MEM_data_WB, exp_data);
        check("addr_err", {31'd0, addr_err}, {31'd0, memop & ~ok});
        if (w && ok) mem_m[off / 4] = sv;
        if (hw) hi_m = hv;
        check("hi_reg", HI_reg, hi_m);
    endtask

    initial begin
        logic [W-1:0] a;
        int kind;
        hi_m = '0;
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_freeze", {31'd0, freeze}, '0);
        check("rst_alu_mem", ALU_res_MEM, '0);
        check("rst_wb", {25'd0, WB_EN_WB, MEM_R_EN_WB, dest_WB}, '0);
        check("rst_data", ALU_res_WB | MEM_data_WB, '0);
        check("rst_hi", HI_reg, '0);
        check("rst_err", {31'd0, addr_err}, '0);
        rst = 0;

        run_op(0, 0, 1, 0, 5'd5, 32'h1234, 0, 0);

        for (int i = 0; i < DEP; i++)
            run_op(0, 1, 0, 0, 0, W'(BASE + 4 * i), $urandom, 0);

        run_op(0, 1, 0, 0, 0, 32'd1028, 32'hDEADBEEF, 0);
        run_op(1, 0, 1, 0, 5'd9, 32'd1028, 0, 0);
        run_op(1, 0, 1, 0, 5'd3, 32'd1026, 0, 0);
        run_op(1, 0, 1, 0, 5'd3, W'(BASE + 4 * DEP), 0, 0);
        run_op(1, 1, 1, 0, 5'd4, 32'd1032, 32'd7, 0);
        run_op(1, 0, 1, 0, 5'd4, 32'd1032, 0, 0);
        run_op(0, 1, 0, 1, 0, 32'd1036, 32'h11, 32'hA5A5);
        run_op(0, 0, 0, 1, 0, 32'd0, 0, 32'h5A5A);

        // Reset lands in the first WAIT cycle of a store; store must vanish.
        @(negedge clk);
        w_en = 1; alu = 32'd1040; stv = 32'h55;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        check("mid_rst_freeze", {31'd0, freeze}, '0);
        check("mid_rst_alu", ALU_res_MEM, '0);
        check("mid_rst_hi", HI_reg, '0);
        hi_m = '0;
        @(negedge clk);
        rst = 0;
        run_op(1, 0, 1, 0, 5'd7, 32'd1040, 0, 0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 1) ? $urandom
                    : W'(BASE - 8 + $urandom_range(0, 4 * DEP + 16));
            else
                a = W'(BASE + 4 * $urandom_range(0, DEP - 1));
            run_op(kind == 1 || kind == 3, kind >= 2,
                   1'($urandom), $urandom_range(0, 3) == 0,
                   5'($urandom), a, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
